btn_step_conditioner: RTL and testbench

- Upstream stage for the LED state-stepping block. It conditions a raw push-button into clean, single-cycle step requests.
- Synchronises the asynchronous button and debounces both edges with a counter-based FSM.
- Emits one-cycle press, release and auto-repeat pulses, plus a debounced level.
- step_pulse drives the downstream block's p input directly, so the downstream block needs no internal delay loops.

---
 rtl/btn_step_conditioner.sv | 145 ++++++++++++++
 tb/tb_btn_step_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_step_conditioner.sv
// Push-button conditioner: two-flop synchroniser, counter-based debounce of
// both edges, and one-cycle press / release / auto-repeat pulses. step_pulse
// is the OR of the registered press and repeat pulses and feeds the
// downstream stepping block directly.
module btn_step_conditioner #(
    parameter int unsigned DEB_CYCLES = 100000,
    parameter bit          REPEAT_EN  = 1'b1,
    parameter int unsigned REPEAT_DLY = 50000000,
    parameter int unsigned REPEAT_PER = 10000000,
    parameter int unsigned CNT_W      = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_DN,
        HELD,
        DEB_UP
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

    logic             sync1;
    logic             btn_s;
    state_t           state,        state_d;
    logic [CNT_W-1:0] cnt,          cnt_d;
    logic [CNT_W-1:0] rep_cnt,      rep_cnt_d;
    logic             rep_periodic, rep_periodic_d;
    logic             level_d;
    logic             press_d;
    logic             release_d;
    logic             repeat_d;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_in;
            btn_s <= sync1;
        end
    end

    // State, counters, repeat phase and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rep_cnt       <= '0;
            rep_periodic  <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            rep_cnt       <= rep_cnt_d;
            rep_periodic  <= rep_periodic_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            repeat_pulse  <= repeat_d;
        end
    end

    // Debounce FSM next-state, counter updates and pulse generation.
    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        rep_cnt_d      = rep_cnt;
        rep_periodic_d = rep_periodic;
        level_d        = btn_level;
        press_d        = 1'b0;
        release_d      = 1'b0;
        repeat_d       = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_d = DEB_DN;
                    cnt_d   = '0;
                end
            end
            DEB_DN: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_d        = HELD;
                    press_d        = 1'b1;
                    level_d        = 1'b1;
                    rep_cnt_d      = '0;
                    rep_periodic_d = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = DEB_UP;
                    cnt_d   = '0;
                end else if (REPEAT_EN) begin
                    if (!rep_periodic && rep_cnt == DLY_LAST) begin
                        repeat_d       = 1'b1;
                        rep_cnt_d      = '0;
                        rep_periodic_d = 1'b1;
                    end else if (rep_periodic && rep_cnt == PER_LAST) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt + 1'b1;
                    end
                end
            end
            DEB_UP: begin
                // A release glitch returns to HELD with rep_cnt left frozen.
                if (btn_s) begin
                    state_d = HELD;
                end else if (cnt == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign step_pulse = press_pulse | repeat_pulse;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Directed bench for btn_step_conditioner. Expected pulse events are derived
// from the edge-count rules and queued when stimulus is driven; every cycle
// all outputs of two instances (auto-repeat on and off) are compared.
module tb_btn_step_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;

    logic lvl, prs, rel, rpt, stp;
    logic lvl0, prs0, rel0, rpt0, stp0;

    btn_step_conditioner #(
        .DEB_CYCLES (4),
        .REPEAT_EN  (1'b1),
        .REPEAT_DLY (20),
        .REPEAT_PER (8),
        .CNT_W      (28)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (lvl),
        .press_pulse   (prs),
        .release_pulse (rel),
        .repeat_pulse  (rpt),
        .step_pulse    (stp)
    );

    btn_step_conditioner #(
        .DEB_CYCLES (4),
        .REPEAT_EN  (1'b0),
        .REPEAT_DLY (20),
        .REPEAT_PER (8),
        .CNT_W      (28)
    ) dut0 (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (lvl0),
        .press_pulse   (prs0),
        .release_pulse (rel0),
        .repeat_pulse  (rpt0),
        .step_pulse    (stp0)
    );

    always #5 clk = ~clk;

    // Event kinds: 1 = press, 2 = release, 3 = repeat.
    typedef struct {
        int t;
        int k;
    } ev_t;

    ev_t  q[$];
    int   ec      = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_step  = 0;
    int   n_step0 = 0;
    int   n_rep   = 0;
    logic lvl_exp = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s edge=%0d observed=%b expected=%b", tag, ec, obs, exp);
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic push(input int t, input int k);
        ev_t e;
        int  i;
        e.t = t;
        e.k = k;
        i = 0;
        while (i < q.size() && q[i].t <= t) i++;
        q.insert(i, e);
    endtask

    // Advance one clock, then compare every output against the scoreboard.
    task automatic cycle();
        int k;
        @(posedge clk);
        #1;
        ec++;
        k = 0;
        if (q.size() > 0 && q[0].t == ec) begin
            k = q[0].k;
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].t < ec) begin
            chk_i("missed_event", q[0].t, ec);
            void'(q.pop_front());
        end
        if (k == 1) lvl_exp = 1'b1;
        if (k == 2) lvl_exp = 1'b0;
        chk("press",    prs,  k == 1);
        chk("release",  rel,  k == 2);
        chk("repeat",   rpt,  k == 3);
        chk("step",     stp,  k == 1 || k == 3);
        chk("level",    lvl,  lvl_exp);
        chk("press0",   prs0, k == 1);
        chk("release0", rel0, k == 2);
        chk("repeat0",  rpt0, 1'b0);
        chk("step0",    stp0, k == 1);
        chk("level0",   lvl0, lvl_exp);
        if (stp)  n_step++;
        if (stp0) n_step0++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Button high for h samples then low for low samples, first high sample
    // at edge E = ec+1: press at E+6, repeats at E+26, E+34, ... while the
    // FSM still sees the button high (through edge E+h+1), release at E+h+6.
    task automatic hold(input int h, input int low);
        int e;
        e = ec + 1;
        n_rep = 0;
        if (h >= 5) begin
            push(e + 6, 1);
            for (int t = e + 26; t <= e + h + 1; t += 8) begin
                push(t, 3);
                n_rep++;
            end
            if (low >= 5) push(e + h + 6, 2);
        end
        btn_in = 1'b1;
        run(h);
        btn_in = 1'b0;
        run(low);
    endtask

    initial begin
        int e;
        rst    = 1'b0;
        btn_in = 1'b0;
        run(3);
        rst = 1'b1;
        run(3);

        // Clean press and release.
        n_step = 0;
        hold(12, 10);
        chk_i("clean_steps", n_step, 1);

        // Bounce: 3 high, 5 low, 2 high, low -> nothing accepted.
        btn_in = 1'b1;
        run(3);
        btn_in = 1'b0;
        run(5);
        btn_in = 1'b1;
        run(2);
        btn_in = 1'b0;
        run(10);

        // Release glitch in HELD: 2 low samples, then high again.
        e = ec + 1;
        push(e + 6, 1);
        push(e + 22, 2);
        btn_in = 1'b1;
        run(10);
        btn_in = 1'b0;
        run(2);
        btn_in = 1'b1;
        run(4);
        btn_in = 1'b0;
        run(10);

        // Long hold with auto-repeat (and none on the REPEAT_EN=0 copy).
        n_step  = 0;
        n_step0 = 0;
        hold(60, 10);
        chk_i("long_steps",  n_step,  1 + n_rep);
        chk_i("long_steps0", n_step0, 1);

        // Asynchronous reset while HELD, then restart with the button high.
        e = ec + 1;
        push(e + 6, 1);
        btn_in = 1'b1;
        run(10);
        rst = 1'b0;
        #2;
        chk("rst_level",   lvl, 1'b0);
        chk("rst_press",   prs, 1'b0);
        chk("rst_release", rel, 1'b0);
        chk("rst_repeat",  rpt, 1'b0);
        chk("rst_step",    stp, 1'b0);
        chk("rst_level0",  lvl0, 1'b0);
        q.delete();
        lvl_exp = 1'b0;
        run(3);
        rst = 1'b1;
        push(ec + 7, 1);
        run(12);
        btn_in = 1'b0;
        push(ec + 7, 2);
        run(10);

        chk_i("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
